// File: rtl/lenet_weight_loader.sv
// Streams one layer's packed weight/bias block from weight memory into the core's
// weight buffer and bias registers, then pulses weight_loaded_o.
module lenet_weight_loader #(
    parameter int unsigned MEM_AW          = 16,
    parameter int unsigned WBUF_AW         = 10,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic               clk_i,
    input  logic               rst_async_n_i,
    input  logic               req_load_weight_i,
    input  logic [3:0]         layer_id_i,
    output logic               weight_loaded_o,
    output logic               err_o,
    output logic               mem_req_o,
    output logic [MEM_AW-1:0]  mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [31:0]        mem_rdata_i,
    output logic               wbuf_we_o,
    output logic [WBUF_AW-1:0] wbuf_addr_o,
    output logic [31:0]        wbuf_data_o,
    output logic               bias_we_o,
    output logic [2:0]         bias_idx_o,
    output logic [31:0]        bias_data_o
);

    localparam logic [7:0] MaxOut = 8'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

    state_e state_q, state_d;

    logic               req_q;
    logic               req_edge;
    logic [MEM_AW-1:0]  base_q;
    logic [7:0]         wcnt_q, total_q;
    logic [7:0]         issued_q, returned_q, outst_q;
    logic               err_q;
    logic               wbuf_we_q, bias_we_q;
    logic [WBUF_AW-1:0] wbuf_addr_q;
    logic [31:0]        wbuf_data_q, bias_data_q;
    logic [2:0]         bias_idx_q;

    logic               id_valid;
    logic [MEM_AW-1:0]  id_base;
    logic [7:0]         id_wcnt, id_total;
    logic               gnt_acc, rv_acc;

    assign req_edge = req_load_weight_i & ~req_q;
    assign gnt_acc  = mem_req_o & mem_gnt_i;
    // Returns with nothing outstanding (protocol error or aborted load) are dropped.
    assign rv_acc   = (state_q == StFetch) & mem_rvalid_i & (outst_q != 8'd0);

    always_comb begin
        id_valid = 1'b1;
        id_base  = '0;
        id_wcnt  = 8'd225;
        id_total = 8'd231;
        case (layer_id_i)
            4'd1: begin
                id_wcnt  = 8'd38;
                id_total = 8'd44;
            end
            4'd2:    id_base = MEM_AW'(44);
            4'd3:    id_base = MEM_AW'(275);
            4'd4:    id_base = MEM_AW'(506);
            default: id_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_edge) state_d = id_valid ? StFetch : StDone;
            StFetch: if (returned_q == total_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req_o       = (state_q == StFetch) && (issued_q < total_q) && (outst_q < MaxOut);
        mem_addr_o      = base_q + MEM_AW'(issued_q);
        weight_loaded_o = (state_q == StDone);
        err_o           = err_q;
        wbuf_we_o       = wbuf_we_q;
        wbuf_addr_o     = wbuf_addr_q;
        wbuf_data_o     = wbuf_data_q;
        bias_we_o       = bias_we_q;
        bias_idx_o      = bias_idx_q;
        bias_data_o     = bias_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            req_q       <= 1'b0;
            base_q      <= '0;
            wcnt_q      <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            returned_q  <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
            wbuf_we_q   <= 1'b0;
            wbuf_addr_q <= '0;
            wbuf_data_q <= '0;
            bias_we_q   <= 1'b0;
            bias_idx_q  <= '0;
            bias_data_q <= '0;
        end else begin
            req_q     <= req_load_weight_i;
            wbuf_we_q <= 1'b0;
            bias_we_q <= 1'b0;
            if (state_q == StIdle && req_edge) begin
                if (id_valid) begin
                    base_q     <= id_base;
                    wcnt_q     <= id_wcnt;
                    total_q    <= id_total;
                    issued_q   <= '0;
                    returned_q <= '0;
                    outst_q    <= '0;
                    err_q      <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == StFetch) begin
                issued_q <= issued_q + {7'd0, gnt_acc};
                outst_q  <= outst_q + {7'd0, gnt_acc} - {7'd0, rv_acc};
                if (rv_acc) begin
                    returned_q <= returned_q + 8'd1;
                    if (returned_q < wcnt_q) begin
                        wbuf_we_q   <= 1'b1;
                        wbuf_addr_q <= WBUF_AW'(returned_q);
                        wbuf_data_q <= mem_rdata_i;
                    end else begin
                        bias_we_q   <= 1'b1;
                        bias_idx_q  <= 3'(returned_q - wcnt_q);
                        bias_data_q <= mem_rdata_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lenet_weight_loader.sv
// Bench for lenet_weight_loader: memory model with random grant/latency, write
// scoreboard, table of load vectors plus reset / held-request sequences.
module tb_lenet_weight_loader;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  layer_id = 4'd0;
    logic        weight_loaded_o, err_o, mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wbuf_we_o, bias_we_o;
    logic [9:0]  wbuf_addr_o;
    logic [31:0] wbuf_data_o, bias_data_o;
    logic [2:0]  bias_idx_o;

    lenet_weight_loader #(.MEM_AW(16), .WBUF_AW(10), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i             (clk),
        .rst_async_n_i     (rst_n),
        .req_load_weight_i (req),
        .layer_id_i        (layer_id),
        .weight_loaded_o   (weight_loaded_o),
        .err_o             (err_o),
        .mem_req_o         (mem_req_o),
        .mem_addr_o        (mem_addr_o),
        .mem_gnt_i         (mem_gnt),
        .mem_rvalid_i      (mem_rvalid),
        .mem_rdata_i       (mem_rdata),
        .wbuf_we_o         (wbuf_we_o),
        .wbuf_addr_o       (wbuf_addr_o),
        .wbuf_data_o       (wbuf_data_o),
        .bias_we_o         (bias_we_o),
        .bias_idx_o        (bias_idx_o),
        .bias_data_o       (bias_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit bias;
        int idx;
        int data;
    } wr_t;

    typedef struct {
        int id;
        int pct;
        int lmin;
        int lmax;
        int hold;
        int drop;
        int lat;
    } vec_t;

    int  n_vec = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  addr_q[$];
    int  rdy_q[$];
    wr_t exp_q[$];
    int  stale = 0, last_rdy = 0, grant_cnt = 0, done_cnt = 0, done_cyc = 0;
    int  gnt_pct = 100, min_lat = 1, max_lat = 1;
    int  rdy;
    wr_t e;
    vec_t tbl[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void push_block(input int id);
        int base;
        int w;
        wr_t x;
        base = (id == 1) ? 0 : 44 + 231 * (id - 2);
        w    = (id == 1) ? 38 : 225;
        for (int r = 0; r < w + 6; r++) begin
            x.bias = (r >= w);
            x.idx  = (r < w) ? r : r - w;
            x.data = base + r;
            exp_q.push_back(x);
        end
    endfunction

    // Memory model and write monitor share one process so ordering within a cycle is fixed.
    initial begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                check("outstanding_limit", (addr_q.size() - stale) < MAXO, 1);
                check("addr_in_range", mem_addr_o <= 16'd736, 1);
            end
            if (rdy_q.size() > 0 && rdy_q[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'(addr_q.pop_front());
                void'(rdy_q.pop_front());
                if (stale > 0) stale--;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            mem_gnt = ($urandom_range(99) < gnt_pct);
            if (mem_req_o && mem_gnt && rst_n) begin
                rdy = cyc + int'($urandom_range(max_lat, min_lat));
                if (rdy <= last_rdy) rdy = last_rdy + 1;
                last_rdy = rdy;
                addr_q.push_back(int'(mem_addr_o));
                rdy_q.push_back(rdy);
                grant_cnt++;
            end
            if (wbuf_we_o) begin
                check("wbuf_write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wbuf_kind", wbuf_we_o, !e.bias);
                    check("wbuf_addr", wbuf_addr_o, e.idx);
                    check("wbuf_data", wbuf_data_o, e.data);
                end
            end
            if (bias_we_o) begin
                check("bias_write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("bias_kind", bias_we_o, e.bias);
                    check("bias_idx", bias_idx_o, e.idx);
                    check("bias_data", bias_data_o, e.data);
                end
            end
            if (weight_loaded_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_req"}, mem_req_o, 0);
        check({tag, "_wbuf_we"}, wbuf_we_o, 0);
        check({tag, "_bias_we"}, bias_we_o, 0);
        check({tag, "_done"}, weight_loaded_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_wbuf_addr_data"}, {wbuf_addr_o, wbuf_data_o}, 0);
        check({tag, "_bias_idx_data"}, {bias_idx_o, bias_data_o}, 0);
    endtask

    task automatic do_load(input int id, input int pct, input int lmin, input int lmax,
                           input int hold, input int drop, input int lat);
        bit valid;
        int d0;
        int rc;
        valid = (id >= 1 && id <= 4);
        @(negedge clk);
        gnt_pct = pct;
        min_lat = lmin;
        max_lat = lmax;
        d0 = done_cnt;
        if (valid) push_block(id);
        layer_id = 4'(id);
        req = 1'b1;
        rc = cyc;
        @(posedge clk);
        #1;
        check("err_after_edge", err_o, !valid);
        if (!valid) begin
            check("done_at_t0p1", weight_loaded_o, 1);
            check("no_mem_req_invalid", mem_req_o, 0);
        end
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            @(posedge clk);
            #1;
            if (drop >= 0 && cyc - rc >= drop) req = 1'b0;
        end
        check("done_seen", done_cnt - d0, 1);
        if (lat > 0) check("done_latency", done_cyc - rc, lat);
        repeat (hold) @(negedge clk);
        req = 1'b0;
        repeat (8) @(negedge clk);
        check("single_done", done_cnt - d0, 1);
        check("all_writes_seen", exp_q.size(), 0);
        check("err_final", err_o, !valid);
    endtask

    int g0;
    int d1;

    initial begin
        tbl[0] = '{1, 100, 1, 1, 2, -1, 47};
        tbl[1] = '{4, 100, 1, 1, 2, -1, 0};
        tbl[2] = '{2, 50, 1, 6, 2, -1, 0};
        tbl[3] = '{7, 100, 1, 1, 2, -1, 1};
        tbl[4] = '{1, 100, 1, 3, 2, -1, 0};
        tbl[5] = '{0, 100, 1, 1, 2, -1, 1};
        tbl[6] = '{3, 70, 1, 4, 2, -1, 0};

        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            do_load(tbl[i].id, tbl[i].pct, tbl[i].lmin, tbl[i].lmax,
                    tbl[i].hold, tbl[i].drop, tbl[i].lat);
        end

        // Request held high long after done, then dropped mid-load.
        do_load(1, 100, 1, 2, 100, -1, 0);
        do_load(2, 60, 1, 5, 0, 10, 0);

        // Reset in the middle of an ID 3 load with returns still in flight.
        @(negedge clk);
        gnt_pct = 100;
        min_lat = 4;
        max_lat = 6;
        push_block(3);
        layer_id = 4'd3;
        req = 1'b1;
        g0 = grant_cnt;
        d1 = done_cnt;
        for (int i = 0; i < 200 && grant_cnt - g0 < 10; i++) begin
            @(posedge clk);
            #1;
        end
        check("grants_before_reset", grant_cnt - g0 >= 10, 1);
        rst_n = 1'b0;
        exp_q.delete();
        stale = addr_q.size();
        #1;
        check_outputs_zero("midload_reset");
        req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_reset", done_cnt - d1, 0);
        do_load(3, 100, 1, 1, 2, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
